// File: rtl/fft_in_framer_pkg.sv
// Shared definitions for the FFT input framer and the MDC FFT core.
// Frame length and sample width live here so both sides agree.
package fft_in_framer_pkg;

  localparam int unsigned FFT_N = 32;
  localparam int unsigned FFT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP
  } framer_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock dual-pointer RAM FIFO with registered occupancy and synchronous read.
// Read data returns to zero on cycles without a read.
module sample_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_rd_en,
  output logic [DW-1:0]          o_rd_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [DW-1:0] r_rd_data;
  logic          w_wr;
  logic          w_rd;

  assign w_wr      = i_wr_en & (r_level != LW'(DEPTH));
  assign w_rd      = i_rd_en & (r_level != '0);
  assign o_level   = r_level;
  assign o_rd_data = r_rd_data;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end else begin
        r_rd_data <= '0;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fft_in_framer.sv
// Input framing stage for the MDC FFT: buffers an arbitrary-rate sample stream and
// releases each frame as one contiguous N-sample burst with an optional idle gap.
module fft_in_framer
  import fft_in_framer_pkg::*;
#(
  parameter int unsigned W     = FFT_W,
  parameter int unsigned N     = FFT_N,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned GAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [W-1:0]    s_re,
  input  logic signed [W-1:0]    s_im,
  output logic                   valid_in,
  output logic signed [W-1:0]    FFTInRe,
  output logic signed [W-1:0]    FFTInIm,
  output logic                   frame_start,
  output logic                   frame_last,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(N);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [LW-1:0]    w_level;
  logic [2*W-1:0]   w_rd_data;
  logic             w_wr;
  logic             w_rd;
  logic             w_arm;

  framer_state_t    r_state;
  logic [BW-1:0]    r_bcnt;
  logic [GW-1:0]    r_gcnt;
  logic             r_settle;
  logic             r_valid;
  logic             r_start;
  logic             r_last;

  assign s_ready = ~rst & (w_level != LW'(DEPTH));
  assign w_wr    = s_valid & s_ready;

  // One settle cycle in IDLE after every burst keeps bursts from abutting.
  assign w_arm = (r_state == ST_IDLE) & ~r_settle & (w_level >= LW'(N));
  assign w_rd  = w_arm | (r_state == ST_BURST);

  sample_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_data ({s_re, s_im}),
    .i_rd_en   (w_rd),
    .o_rd_data (w_rd_data),
    .o_level   (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bcnt   <= '0;
      r_gcnt   <= '0;
      r_settle <= 1'b0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_valid  <= w_rd;
      r_start  <= w_arm;
      r_last   <= (r_state == ST_BURST) && (r_bcnt == BW'(N - 1));
      r_settle <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_state <= ST_BURST;
            r_bcnt  <= BW'(1);
          end
        end
        ST_BURST: begin
          if (r_bcnt == BW'(N - 1)) begin
            r_bcnt <= '0;
            if (GAP == 0) begin
              r_state  <= ST_IDLE;
              r_settle <= 1'b1;
            end else begin
              r_state <= ST_GAP;
              r_gcnt  <= GW'(GAP - 1);
            end
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
        ST_GAP: begin
          if (r_gcnt == '0) begin
            r_state  <= ST_IDLE;
            r_settle <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt - GW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid_in    = r_valid;
  assign frame_start = r_start;
  assign frame_last  = r_last;
  assign FFTInRe     = w_rd_data[2*W-1:W];
  assign FFTInIm     = w_rd_data[W-1:0];
  assign level       = w_level;

endmodule

// File: tb/tb_fft_in_framer.sv
// Scoreboard bench for fft_in_framer: instance A with GAP=0, instance B with GAP=40.
module tb_fft_in_framer;

  localparam int W  = 9;
  localparam int N  = 32;
  localparam int DP = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_s_valid, a_s_ready, a_v, a_fs, a_fl;
  logic signed [W-1:0] a_s_re, a_s_im, a_re, a_im;
  logic [6:0]          a_level;
  logic                b_s_valid, b_s_ready, b_v, b_fs, b_fl;
  logic signed [W-1:0] b_s_re, b_s_im, b_re, b_im;
  logic [6:0]          b_level;

  fft_in_framer #(.W(W), .N(N), .DEPTH(DP), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .s_re(a_s_re), .s_im(a_s_im), .valid_in(a_v), .FFTInRe(a_re), .FFTInIm(a_im),
    .frame_start(a_fs), .frame_last(a_fl), .level(a_level));

  fft_in_framer #(.W(W), .N(N), .DEPTH(DP), .GAP(40)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_re(b_s_re), .s_im(b_s_im), .valid_in(b_v), .FFTInRe(b_re), .FFTInIm(b_im),
    .frame_start(b_fs), .frame_last(b_fl), .level(b_level));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [2*W-1:0] qa[$];
  logic [2*W-1:0] qb[$];
  int cyc = 0;
  int a_last_acc = 0;
  int b_last_acc = 0;

  // Scoreboard push: every accepted sample is expected back, in order.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_s_valid && a_s_ready) begin
        qa.push_back({a_s_re, a_s_im});
        a_last_acc = cyc;
      end
      if (b_s_valid && b_s_ready) begin
        qb.push_back({b_s_re, b_s_im});
        b_last_acc = cyc;
      end
    end
  end

  int pos[2];
  int idle[2];
  int bursts[2];
  int start_cyc[2];
  bit prev[2];
  int tight_lo = 1000000;
  int tight_hi = -1;
  bit b_full_seen = 1'b0;

  task automatic mon_step(input int id, input logic v, input logic fs, input logic fl,
                          input logic [W-1:0] re, input logic [W-1:0] im,
                          input bit have, input logic [2*W-1:0] e);
    if (rst) begin
      pos[id]  = 0;
      idle[id] = 0;
      prev[id] = 1'b0;
    end else if (v) begin
      if (pos[id] == 0) begin
        bursts[id]++;
        start_cyc[id] = cyc;
        if (prev[id]) begin
          if (id == 1)
            chk("gap_b_ge41", idle[id] >= 41, 1);
          else if (bursts[0] >= tight_lo && bursts[0] <= tight_hi)
            chk("gap_a_exact", idle[id], 1);
          else
            chk("gap_a_ge1", idle[id] >= 1, 1);
        end
      end
      chk(id ? "b_have" : "a_have", have, 1);
      chk(id ? "b_re" : "a_re", re, e[2*W-1:W]);
      chk(id ? "b_im" : "a_im", im, e[W-1:0]);
      chk(id ? "b_start" : "a_start", fs, pos[id] == 0);
      chk(id ? "b_last" : "a_last", fl, pos[id] == N - 1);
      pos[id]++;
      if (pos[id] == N) begin
        pos[id]  = 0;
        prev[id] = 1'b1;
        idle[id] = 0;
      end
    end else begin
      if (pos[id] != 0) begin
        chk(id ? "b_contig" : "a_contig", pos[id], N);
        pos[id]  = 0;
        prev[id] = 1'b1;
        idle[id] = 0;
      end
      idle[id]++;
      chk(id ? "b_idle_out" : "a_idle_out", {fs, fl, re, im}, 0);
    end
  endtask

  logic [2*W-1:0] a_exp, b_exp;
  bit a_have, b_have;

  always @(negedge clk) begin
    a_have = 1'b0;
    a_exp  = '0;
    if (!rst && a_v && qa.size() != 0) begin
      a_exp  = qa.pop_front();
      a_have = 1'b1;
    end
    mon_step(0, a_v, a_fs, a_fl, a_re, a_im, a_have, a_exp);
  end

  always @(negedge clk) begin
    b_have = 1'b0;
    b_exp  = '0;
    if (!rst && b_v && qb.size() != 0) begin
      b_exp  = qb.pop_front();
      b_have = 1'b1;
    end
    mon_step(1, b_v, b_fs, b_fl, b_re, b_im, b_have, b_exp);
    if (!rst && !b_s_ready) begin
      chk("b_full_level", b_level, DP);
      b_full_seen = 1'b1;
    end
  end

  task automatic drive(input int id, input int base, input int n, input int duty, input bit rnd);
    int k = 0;
    int guard = 0;
    logic acc, v;
    logic [W-1:0] re, im;
    @(posedge clk); #1;
    while (k < n && guard < 20000) begin
      if (rnd) begin
        re = W'($urandom);
        im = W'($urandom);
      end else begin
        re = W'(base + k);
        im = W'(-(base + k));
      end
      v = ($urandom_range(99) < duty);
      if (id == 0) begin a_s_valid = v; a_s_re = re; a_s_im = im; end
      else         begin b_s_valid = v; b_s_re = re; b_s_im = im; end
      @(negedge clk);
      acc = v && ((id == 0) ? a_s_ready : b_s_ready);
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    if (id == 0) a_s_valid = 1'b0; else b_s_valid = 1'b0;
    chk("drive_done", k, n);
  endtask

  task automatic wait_burst(input int id, input int target, input int budget);
    int t = 0;
    while (bursts[id] < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("burst_wait", bursts[id] >= target, 1);
  endtask

  task automatic wait_drain(input int id, input int budget);
    int t = 0;
    while (((id == 0 ? qa.size() : qb.size()) != 0 || pos[id] != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain", (id == 0) ? qa.size() : qb.size(), 0);
  endtask

  int nb;
  int t;

  initial begin
    rst = 1'b1;
    a_s_valid = 1'b0; a_s_re = '0; a_s_im = '0;
    b_s_valid = 1'b0; b_s_re = '0; b_s_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", a_s_ready, 0);
    chk("rst_ready_b", b_s_ready, 0);
    chk("rst_level", a_level, 0);
    chk("rst_valid", a_v, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_s_ready, 1);
    chk("post_rst_level", a_level, 0);
    chk("post_rst_out", {a_v, a_fs, a_fl, a_re, a_im}, 0);

    // Single frame: first valid_in one edge after the edge that took the 32nd sample.
    nb = bursts[0];
    drive(0, 0, N, 100, 1'b0);
    wait_burst(0, nb + 1, 100);
    chk("lat_single", start_cyc[0], a_last_acc + 1);
    wait_drain(0, 200);

    // Partial frame waits until the 32nd sample arrives.
    nb = bursts[0];
    drive(0, 0, N - 1, 100, 1'b0);
    repeat (100) @(negedge clk);
    chk("partial_hold", bursts[0], nb);
    chk("partial_level", a_level, N - 1);
    drive(0, N - 1, 1, 100, 1'b0);
    wait_burst(0, nb + 1, 100);
    chk("lat_partial", start_cyc[0], a_last_acc + 1);
    wait_drain(0, 200);

    // Continuous 96-sample stream, crossing the pointer wrap.
    nb = bursts[0];
    tight_lo = nb + 2;
    tight_hi = nb + 3;
    drive(0, 0, 3 * N, 100, 1'b0);
    wait_burst(0, nb + 3, 300);
    wait_drain(0, 300);
    chk("stream_bursts", bursts[0], nb + 3);

    // Random 50% valid over 10 frames.
    nb = bursts[0];
    drive(0, 0, 10 * N, 50, 1'b1);
    wait_drain(0, 3000);
    chk("random_bursts", bursts[0], nb + 10);

    // Mid-burst reset, then a fresh frame.
    drive(0, 0, N, 100, 1'b0);
    t = 0;
    while (pos[0] < 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("midburst_reached", pos[0] >= 10, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", a_v, 0);
    chk("midrst_level", a_level, 0);
    nb = bursts[0];
    drive(0, 200, N, 100, 1'b0);
    wait_burst(0, nb + 1, 100);
    chk("lat_fresh", start_cyc[0], a_last_acc + 1);
    wait_drain(0, 200);

    // Backpressure against the GAP=40 instance.
    nb = bursts[1];
    drive(1, 0, 6 * N, 100, 1'b0);
    wait_drain(1, 3000);
    chk("b_full_seen", b_full_seen, 1);
    chk("b_bursts", bursts[1], nb + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fft_in_framer.md
# fft_in_framer

Input framing stage placed directly upstream of the 32-point MDC FFT core. It accepts complex samples through a valid/ready handshake at an arbitrary rate and buffers them in a two-frame FIFO. It then releases each frame to the core as an uninterrupted burst of exactly N samples, because the core's controller requires `valid_in` contiguous for a whole frame. An optional idle gap between bursts lets the core's stage control sequence settle.

## Interface
- `W`, 9, sample component width (signed, two's complement).
- `N`, 32, samples per FFT frame (power of two).
- `DEPTH`, 64, FIFO depth in samples (power of two, ≥ N).
- `GAP`, 0, minimum idle cycles between the last sample of one burst and the first sample of the next.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  framer can accept a sample.
- `s_re`, `s_im`  in  W each  upstream sample, signed.
- `valid_in`  out  1  to FFT core; high for exactly N consecutive cycles per frame.
- `FFTInRe`, `FFTInIm`  out  W each  to FFT core, signed.
- `frame_start`  out  1  high with the first sample of each burst.
- `frame_last`  out  1  high with the N-th sample of each burst.
- `level`  out  log2(DEPTH)+1  registered FIFO occupancy.

## Operation
- A sample is accepted on any edge where `s_valid && s_ready`. Accepted samples are written at `wr_ptr`, which then increments modulo DEPTH.
- `s_ready = (level != DEPTH)`. It is driven from the registered level only, with no same-cycle bypass from a read.
- `level` update per edge: +1 on write only, −1 on read only, unchanged on simultaneous write and read, or when neither occurs.
- States:
  - **IDLE:** when `level >= N`, go to BURST and issue read 0 this cycle.
  - **BURST:** issue one read per cycle using burst counter `bcnt` (0..N−1, log2(N) bits). After read N−1: if GAP=0 go to IDLE, otherwise go to GAP and load the gap counter with GAP−1.
  - **GAP:** count down the gap counter; at 0 go to IDLE.
- GAP=0 with `level >= 2N` at the end of a burst: IDLE immediately re-arms, giving exactly one idle cycle between bursts. Back-to-back bursts with no idle cycle are not supported.
- Read data is registered. `valid_in`, `FFTInRe/Im`, `frame_start` and `frame_last` appear one cycle after the read is issued.
- No reads are issued outside BURST, so the FIFO never underflows. A partial frame (`level < N`) waits indefinitely.
- Samples pass through unmodified: no scaling, no rounding, no sign change.
- When `valid_in` is 0, `FFTInRe/Im` hold 0, not stale data.

## Timing
- Reset values: `s_ready`=0 during reset and 1 on the first cycle after it. `valid_in`, `frame_start`, `frame_last` = 0. `FFTInRe/Im` = 0. `level` = 0. State = IDLE; `bcnt`, gap counter and both pointers = 0.
- Latency: the N-th sample of a frame accepted at edge t → `level` = N after t → read 0 issued in cycle t+1 → first `valid_in` in cycle t+2.
- `valid_in` high for exactly N cycles. `frame_start` is high in the first of them and `frame_last` in the last.
- With GAP=g>0: `valid_in` is low for at least g+1 cycles between bursts.
- Pointer wrap: both pointers wrap DEPTH−1 → 0 with no effect on the data stream.
- Reset during a burst: the burst is aborted and FIFO contents are discarded. On the cycle after `rst` deasserts, `valid_in`=0 and `level`=0. The FFT core is reset together with the framer.

## Structure
- Shared package holds `FFT_N` = 32, `FFT_W` = 9, and the state enum `framer_state_t` {IDLE, BURST, GAP}, so the core and the framer agree on frame length.
- One sub-module, `sample_fifo`: a single-clock dual-pointer RAM FIFO holding W+W bits, with `level` and synchronous read.
- The FSM, burst counter and gap counter live in `fft_in_framer`.

## Test plan
- **Single frame:** write re=k, im=−k for k=0..31, one per cycle, from edge t → `valid_in` high in cycles t+33..t+64 with FFTInRe=0..31, FFTInIm=0..−31. `frame_start` is high at t+33 and `frame_last` at t+64.
- **Partial frame:** write 31 samples, idle 100 cycles, write the 32nd → no `valid_in` before the 32nd is accepted; burst starts 2 cycles after that acceptance.
- **Continuous stream, GAP=0:** write 96 samples back to back → three bursts of 32, each separated by exactly one idle cycle. Output equals input order, including across the pointer wrap at 64.
- **Backpressure, GAP=40:** hold `s_valid`=1 with a continuous stream → `s_ready` drops when `level` reaches 64 and no sample is lost or duplicated. Each gap is ≥ 41 cycles.
- **Random `s_valid` (50% duty):** over 10 frames → every burst is contiguous for 32 cycles and the output sequence matches the accepted sequence.
- **Mid-burst reset:** assert `rst` at burst cycle 10 for 1 cycle → next cycle `valid_in`=0, `level`=0. A fresh 32-sample frame then produces a burst starting with its first sample.
